// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - decode fields in, datapath controls out
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [1:0] RegSrc;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, RegSrc, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, RegSrc, State
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle ARM-subset sequencer with NZCV flags
// Outputs are Moore: functions of state, IR fields and the latched condition result.
module multicycle_control_fsm (
  input  logic clk,
  input  logic rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;
  logic       cond_ex_reg, cond_ex;
  logic [3:0] cmd;
  logic [1:0] alu_op;
  logic       is_cmp, unsupported, arith;
  logic       rd_is_pc;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control;

  assign cmd      = bus.Funct[4:1];
  assign rd_is_pc = (bus.Rd == 4'd15);

  always_comb begin
    alu_op      = 2'b00;
    is_cmp      = 1'b0;
    unsupported = 1'b0;
    arith       = 1'b0;
    case (cmd)
      4'b0100: arith = 1'b1;
      4'b0010: begin alu_op = 2'b01; arith = 1'b1; end
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      4'b1010: begin alu_op = 2'b01; arith = 1'b1; is_cmp = 1'b1; end
      default: unsupported = 1'b1;
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  // Flags written at the end of Execute are seen by the next Decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      if (state == DECODE) cond_ex_reg <= cond_ex;
      if ((state == EXECR || state == EXECI) && bus.Funct[0] && cond_ex_reg && !unsupported) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (arith) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = bus.Funct[5] ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = bus.Funct[0] ? MEMREAD : MEMWR;
      MEMREAD: next_state = MEMWB;
      EXECR:   next_state = ALUWB;
      EXECI:   next_state = ALUWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    result_src  = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR:  alu_src_b = 2'b01;
      MEMREAD: adr_src   = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        if (rd_is_pc) pc_write  = cond_ex_reg;
        else          reg_write = cond_ex_reg;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_reg;
      end
      EXECR:   alu_control = alu_op;
      EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_op;
      end
      ALUWB: begin
        if (rd_is_pc) pc_write  = cond_ex_reg;
        else          reg_write = cond_ex_reg & ~is_cmp & ~unsupported;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex_reg;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset so nothing completes once rst falls.
  assign bus.PCWrite    = pc_write & rst;
  assign bus.IRWrite    = ir_write & rst;
  assign bus.MemWrite   = mem_write & rst;
  assign bus.RegWrite   = reg_write & rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench with instruction-level reference model
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw;
    logic [1:0] rs;
    logic       sa;
    logic [1:0] sb, alu, imm;
    logic       rw;
    logic [1:0] rsrc;
  } vec_t;

  vec_t exp_q[$];
  int   tests = 0, fails = 0, pushed = 0, popped = 0;
  logic [3:0] mflags = 4'b0000;

  function automatic vec_t sample();
    vec_t a;
    a.st = bus.State; a.pcw = bus.PCWrite; a.adr = bus.AdrSrc; a.memw = bus.MemWrite;
    a.irw = bus.IRWrite; a.rs = bus.ResultSrc; a.sa = bus.ALUSrcA; a.sb = bus.ALUSrcB;
    a.alu = bus.ALUControl; a.imm = bus.ImmSrc; a.rw = bus.RegWrite; a.rsrc = bus.RegSrc;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every cycle that has a scheduled expectation is compared.
  always @(negedge clk) begin
    vec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      popped++;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_vec state=%0d: got %h expected %h", e.st, a, e);
      end
    end
  end

  // Condition pairs: even code tests a predicate, odd code its inverse.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input bit force_af, input logic [3:0] af_val);
    int seq[$];
    bit ce, ok, carry_ops, cmp;
    logic [1:0] aluc;
    logic [3:0] cmd, af, af_exec;
    vec_t v;
    ce  = cond_holds(cond, mflags);
    cmd = funct[4:1];
    ok = 1; carry_ops = 1; cmp = 0; aluc = 2'b00;
    if (cmd == 4'd4) aluc = 2'b00;
    else if (cmd == 4'd2) aluc = 2'b01;
    else if (cmd == 4'd0) begin aluc = 2'b10; carry_ops = 0; end
    else if (cmd == 4'd12) begin aluc = 2'b11; carry_ops = 0; end
    else if (cmd == 4'd10) begin aluc = 2'b01; cmp = 1; end
    else ok = 0;
    seq.push_back(0); seq.push_back(1);
    if (op == 2'b01) begin
      seq.push_back(2);
      if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
      else seq.push_back(5);
    end else if (op == 2'b00) begin
      seq.push_back(funct[5] ? 7 : 6); seq.push_back(8);
    end else if (op == 2'b10) seq.push_back(9);
    af_exec = 4'b0000;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 0) begin bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; end
      af = (force_af && (seq[k] == 6 || seq[k] == 7)) ? af_val : 4'($urandom_range(0, 15));
      bus.ALUFlags = af;
      v = '0;
      v.st = 4'(seq[k]); v.imm = op; v.rsrc = {op == 2'b01, op == 2'b10};
      case (seq[k])
        0: begin v.irw = 1; v.sa = 1; v.sb = 2; v.rs = 2; v.pcw = 1; end
        1: begin v.sa = 1; v.sb = 2; v.rs = 2; end
        2: v.sb = 1;
        3: v.adr = 1;
        4: begin v.rs = 1; if (rd == 15) v.pcw = ce; else v.rw = ce; end
        5: begin v.adr = 1; v.memw = ce; end
        6, 7: begin v.sb = (seq[k] == 7) ? 2'd1 : 2'd0; v.alu = aluc; af_exec = af; end
        8: begin if (rd == 15) v.pcw = ce; else v.rw = ce && !cmp && ok; end
        default: begin v.sb = 1; v.rs = 2; v.pcw = ce; end
      endcase
      exp_q.push_back(v);
      pushed++;
    end
    if (op == 2'b00 && funct[0] && ce && ok) begin
      mflags[3:2] = af_exec[3:2];
      if (carry_ops) mflags[1:0] = af_exec[1:0];
    end
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int count);
    logic [3:0] rd;
    for (int i = 0; i < count; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                rd, 1'b0, 4'b0000);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b101000; bus.Rd = 4'd1; bus.ALUFlags = 4'b0000;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_state", 32'(bus.State), 32'd0);
      check("reset_pcwrite", 32'(bus.PCWrite), 32'd0);
      check("reset_irwrite", 32'(bus.IRWrite), 32'd0);
      check("reset_wr_en", 32'({bus.MemWrite, bus.RegWrite}), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    run_instr(4'b1110, 2'b00, 6'b101000, 4'd1, 1'b0, 4'b0000);  // ADD r1,r2,#5
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 1'b1, 4'b0100);  // CMP sets Z
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 1'b0, 4'b0000);  // BEQ taken
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 1'b1, 4'b0000);  // CMP clears flags
    run_instr(4'b0000, 2'b01, 6'b000001, 4'd3, 1'b0, 4'b0000);  // LDR cond fails
    run_instr(4'b1110, 2'b01, 6'b000000, 4'd3, 1'b0, 4'b0000);  // STR
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd15, 1'b0, 4'b0000); // ADD to PC
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd2, 1'b0, 4'b0000);  // undefined
    run_random(150);

    // Set Z, then reset during MemRead of an LDR.
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 1'b1, 4'b0100);
    bus.Cond = 4'b1110; bus.Op = 2'b01; bus.Funct = 6'b000001; bus.Rd = 4'd4;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_memread", 32'(bus.State), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_reset_state", 32'(bus.State), 32'd0);
    check("async_reset_writes", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
    @(negedge clk);
    check("held_reset_state", 32'(bus.State), 32'd0);
    check("held_reset_regwrite", 32'(bus.RegWrite), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mflags = 4'b0000;
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 1'b0, 4'b0000);  // BEQ not taken: Z cleared
    run_random(100);

    @(negedge clk);
    check("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
